// File: rtl/osd_mam_wb_mem.sv
// osd_mam_wb_mem: Wishbone B3 responder backed by an internal word-addressed RAM.
// Handles classic cycles and registered-feedback incrementing bursts (linear and
// wrap-4/8/16). Accesses outside [BASE_ADDR, BASE_ADDR+MEM_SIZE) are answered
// with err_o. All outputs are registered.
module osd_mam_wb_mem #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    MEM_SIZE   = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      cyc_i,
  input  logic                      stb_i,
  input  logic                      we_i,
  input  logic [ADDR_WIDTH-1:0]     addr_i,
  input  logic [DATA_WIDTH-1:0]     dat_i,
  input  logic [DATA_WIDTH/8-1:0]   sel_i,
  input  logic [2:0]                cti_i,
  input  logic [1:0]                bte_i,
  output logic                      ack_o,
  output logic                      err_o,
  output logic [DATA_WIDTH-1:0]     dat_o
);

  localparam int SW    = DATA_WIDTH / 8;
  localparam int LSW   = $clog2(SW);
  localparam int DEPTH = MEM_SIZE / SW;
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Range bounds carry one extra bit so BASE_ADDR+MEM_SIZE cannot overflow.
  localparam logic [ADDR_WIDTH:0] LO_X   = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0] HI_X   = LO_X + (ADDR_WIDTH+1)'(MEM_SIZE);
  localparam logic [ADDR_WIDTH:0] STEP_X = (ADDR_WIDTH+1)'(SW);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACK   = 2'd1;
  localparam logic [1:0] S_ERR   = 2'd2;
  localparam logic [1:0] S_BURST = 2'd3;

  localparam logic [2:0] CTI_INC = 3'b010;
  localparam logic [2:0] CTI_END = 3'b111;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] baddr;

  logic                  valid, req_in, beat, wr_en, next_ok;
  logic [IW-1:0]         req_idx, wr_idx, next_idx;
  logic [ADDR_WIDTH-1:0] woff, wmask, wnew;
  logic [ADDR_WIDTH:0]   next_x;
  logic [DATA_WIDTH-1:0] rd_next;

  function automatic logic in_range(input logic [ADDR_WIDTH:0] a);
    return (a >= LO_X) && (a < HI_X);
  endfunction

  // Sub-word address bits are dropped; the index is relative to BASE_ADDR.
  function automatic logic [IW-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return IW'((a - BASE_ADDR) >> LSW);
  endfunction

  // Request decode, burst address prediction and next-word read with write forwarding.
  always_comb begin
    valid    = cyc_i & stb_i;
    req_in   = in_range({1'b0, addr_i});
    req_idx  = word_idx(addr_i);
    beat     = (state == S_BURST) && valid && (cti_i == CTI_INC || cti_i == CTI_END);
    wr_en    = we_i && (((state == S_ACK) && valid) || beat);
    wr_idx   = word_idx(baddr);

    woff = (baddr - BASE_ADDR) >> LSW;
    case (bte_i)
      2'b01:   wmask = ADDR_WIDTH'(3);
      2'b10:   wmask = ADDR_WIDTH'(7);
      2'b11:   wmask = ADDR_WIDTH'(15);
      default: wmask = '0;
    endcase
    // Wrap: low word-index bits count modulo N, upper bits stay put.
    wnew = (woff & ~wmask) | ((woff + ADDR_WIDTH'(1)) & wmask);
    if (bte_i == 2'b00) next_x = {1'b0, baddr} + STEP_X;
    else                next_x = LO_X + ({1'b0, wnew} << LSW);

    next_ok  = in_range(next_x);
    next_idx = word_idx(next_x[ADDR_WIDTH-1:0]);

    // The beat being written this cycle may target the word read for the next beat.
    rd_next = mem[next_idx];
    if (wr_en && (next_idx == wr_idx)) begin
      for (int k = 0; k < SW; k++) begin
        if (sel_i[k]) rd_next[8*k +: 8] = dat_i[8*k +: 8];
      end
    end
  end

  // Byte-lane memory write; contents are intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int k = 0; k < SW; k++) begin
        if (sel_i[k]) mem[wr_idx][8*k +: 8] <= dat_i[8*k +: 8];
      end
    end
  end

  // Bus FSM with registered ack/err/data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= S_IDLE;
      ack_o <= 1'b0;
      err_o <= 1'b0;
      dat_o <= '0;
      baddr <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          ack_o <= 1'b0;
          err_o <= 1'b0;
          if (valid) begin
            baddr <= addr_i;
            if (req_in) begin
              dat_o <= mem[req_idx];
              ack_o <= 1'b1;
              state <= (cti_i == CTI_INC) ? S_BURST : S_ACK;
            end else begin
              dat_o <= '0;
              err_o <= 1'b1;
              state <= S_ERR;
            end
          end
        end
        S_BURST: begin
          if (beat) begin
            baddr <= next_x[ADDR_WIDTH-1:0];
            if (cti_i == CTI_END) begin
              ack_o <= 1'b0;
              state <= S_IDLE;
            end else if (next_ok) begin
              dat_o <= rd_next;
              ack_o <= 1'b1;
            end else begin
              // Linear run past the end of memory: error the next beat.
              dat_o <= '0;
              ack_o <= 1'b0;
              err_o <= 1'b1;
              state <= S_ERR;
            end
          end else begin
            ack_o <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: begin
          // ACK and ERR both last exactly one cycle.
          ack_o <= 1'b0;
          err_o <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_osd_mam_wb_mem.sv
// Self-checking bench for osd_mam_wb_mem: random and directed Wishbone traffic
// compared against a word-array reference memory and closed-form burst addressing.
module tb_osd_mam_wb_mem;

  localparam logic [31:0] BASE = 32'h1000;
  localparam logic [31:0] LAST = 32'h1400;

  logic        clk, rst_n, cyc, stb, we, ack, err;
  logic [31:0] addr, dat_w, dat_r;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;

  int vectors, miscompares;

  logic [31:0] ref_mem [256];
  logic [31:0] bdat [32];
  logic [31:0] wdat [32];
  logic [3:0]  wsel [32];

  // driver results
  logic        ga, ge;
  logic [31:0] rd;
  int          ncyc, nacks, nfirst;

  osd_mam_wb_mem #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_SIZE(1024), .BASE_ADDR(BASE)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .cyc_i(cyc), .stb_i(stb), .we_i(we),
    .addr_i(addr), .dat_i(dat_w), .sel_i(sel), .cti_i(cti), .bte_i(bte),
    .ack_o(ack), .err_o(err), .dat_o(dat_r)
  );

  always #5 clk = ~clk;

  // ack and err must never be asserted together
  always @(negedge clk) begin
    if (rst_n) begin
      vectors++;
      if (ack && err) begin
        miscompares++;
        $display("FAIL ack_err_exclusive: ack=%b err=%b required not both", ack, err);
      end
    end
  end

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  function automatic bit in_rng(input logic [31:0] a);
    return (a >= BASE) && (a < LAST);
  endfunction

  function automatic void ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int w = widx(a);
    for (int k = 0; k < 4; k++) if (s[k]) ref_mem[w][8*k +: 8] = d[8*k +: 8];
  endfunction

  // Address of beat i of a burst starting at a, from the burst rules directly.
  function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [1:0] b, input int i);
    int w, nn;
    if (b == 2'b00) return a + 32'(4 * i);
    nn = 2 << b;
    w  = int'((a - BASE) >> 2);
    return BASE + 32'(4 * ((w / nn) * nn + (w % nn + i) % nn));
  endfunction

  task automatic idle_bus();
    cyc = 0; stb = 0; we = 0; cti = 3'b000; bte = 2'b00; sel = 4'h0;
  endtask

  // Classic single access; holds the request through the ack cycle.
  task automatic wb_classic(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s);
    ga = 0; ge = 0; rd = '0; ncyc = 0;
    cyc = 1; stb = 1; we = w; addr = a; dat_w = d; sel = s; cti = 3'b000; bte = 2'b00;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); ncyc++;
      if (ack || err) begin
        ga = ack; ge = err; rd = dat_r;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    idle_bus();
  endtask

  // Incrementing burst of n beats; stop_after>0 drops the strobe after that many acks.
  task automatic wb_burst(input logic [31:0] a, input logic w, input logic [1:0] b, input int n, input int stop_after);
    logic a_s, e_s;
    nacks = 0; ge = 0; ncyc = 0; nfirst = -1;
    cyc = 1; stb = 1; we = w; addr = a; bte = b; dat_w = wdat[0]; sel = wsel[0]; cti = 3'b010;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk); ncyc++;
      a_s = ack; e_s = err;
      if (e_s) ge = 1;
      if (a_s) begin
        bdat[nacks] = dat_r;
        if (nfirst < 0) nfirst = ncyc;
        nacks++;
      end
      @(posedge clk); #1;
      if (e_s) break;
      if (a_s) begin
        if (nacks == n || (stop_after > 0 && nacks == stop_after)) break;
        dat_w = wdat[nacks]; sel = wsel[nacks];
        cti   = (stop_after == 0 && nacks == n - 1) ? 3'b111 : 3'b010;
        addr  = $urandom;  // must be ignored mid-burst
      end
    end
    idle_bus();
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (ack !== 1'b0) begin miscompares++; $display("FAIL reset_ack: got %b want 0", ack); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", err); end
    vectors++; if (dat_r !== 32'h0) begin miscompares++; $display("FAIL reset_dat: got %h want 0", dat_r); end
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_fill();
    logic [31:0] d;
    for (int i = 0; i < 256; i++) begin
      d = $urandom;
      wb_classic(BASE + 32'(4 * i), 1'b1, d, 4'hF);
      ref_write(BASE + 32'(4 * i), d, 4'hF);
      vectors++;
      if ({ga, ge} !== 2'b10 || ncyc != 2) begin
        miscompares++; $display("FAIL fill_write[%0d]: ack=%b err=%b cycles=%0d want ack in cycle 2", i, ga, ge, ncyc);
      end
    end
  endtask

  task automatic test_classic();
    wb_classic(32'h1008, 1'b1, 32'hDEADBEEF, 4'hF);
    ref_write(32'h1008, 32'hDEADBEEF, 4'hF);
    vectors++; if ({ga, ge} !== 2'b10) begin miscompares++; $display("FAIL classic_wr_ack: ack=%b err=%b want 1/0", ga, ge); end
    vectors++; if (ncyc != 2) begin miscompares++; $display("FAIL classic_wr_cycles: got %0d want 2", ncyc); end
    @(negedge clk);
    vectors++; if (ack !== 1'b0) begin miscompares++; $display("FAIL classic_ack_one_cycle: got %b want 0", ack); end
    @(posedge clk); #1;
    wb_classic(32'h1008, 1'b0, 32'h0, 4'hF);
    vectors++; if (ga !== 1'b1 || ncyc != 2) begin miscompares++; $display("FAIL classic_rd_ack: ack=%b cycles=%0d want 1 in cycle 2", ga, ncyc); end
    vectors++; if (rd !== 32'hDEADBEEF) begin miscompares++; $display("FAIL classic_rd_data: got %h want deadbeef", rd); end
  endtask

  task automatic test_byte_enables();
    wb_classic(32'h1004, 1'b1, 32'h0, 4'hF);          ref_write(32'h1004, 32'h0, 4'hF);
    wb_classic(32'h1004, 1'b1, 32'hAABBCCDD, 4'b0101); ref_write(32'h1004, 32'hAABBCCDD, 4'b0101);
    wb_classic(32'h1004, 1'b0, 32'h0, 4'hF);
    vectors++; if (rd !== 32'h00BB00DD) begin miscompares++; $display("FAIL byte_enable: got %h want 00bb00dd", rd); end
    // sel=0 acks but writes nothing
    wb_classic(32'h1004, 1'b1, 32'h12345678, 4'b0000);
    vectors++; if (ga !== 1'b1) begin miscompares++; $display("FAIL sel0_ack: got %b want 1", ga); end
    wb_classic(32'h1004, 1'b0, 32'h0, 4'hF);
    vectors++; if (rd !== 32'h00BB00DD) begin miscompares++; $display("FAIL sel0_nowrite: got %h want 00bb00dd", rd); end
  endtask

  task automatic test_random_classic();
    logic [31:0] a, d;
    logic [3:0]  s;
    for (int i = 0; i < 60; i++) begin
      a = BASE + 32'(4 * $urandom_range(0, 255)) + 32'($urandom_range(0, 3));
      d = $urandom; s = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        wb_classic(a, 1'b1, d, s);
        ref_write(a, d, s);
        vectors++; if (ga !== 1'b1) begin miscompares++; $display("FAIL rand_wr_ack @%h: got %b want 1", a, ga); end
      end else begin
        wb_classic(a, 1'b0, d, s);
        vectors++;
        if (ga !== 1'b1 || rd !== ref_mem[widx(a)]) begin
          miscompares++; $display("FAIL rand_rd @%h: ack=%b data=%h want %h", a, ga, rd, ref_mem[widx(a)]);
        end
      end
    end
  endtask

  task automatic test_burst_linear();
    for (int i = 0; i < 4; i++) begin wdat[i] = 32'(i + 1); wsel[i] = 4'hF; end
    wb_burst(32'h1010, 1'b1, 2'b00, 4, 0);
    for (int i = 0; i < nacks && i < 4; i++) ref_write(beat_addr(32'h1010, 2'b00, i), wdat[i], wsel[i]);
    vectors++; if (nacks != 4 || ge !== 1'b0) begin miscompares++; $display("FAIL lin_wr_acks: got %0d err=%b want 4/0", nacks, ge); end
    vectors++; if (nfirst != 2 || ncyc != 5) begin miscompares++; $display("FAIL lin_wr_timing: first=%0d total=%0d want 2/5", nfirst, ncyc); end
    @(negedge clk);
    vectors++; if (ack !== 1'b0) begin miscompares++; $display("FAIL lin_wr_end_ack: got %b want 0", ack); end
    @(posedge clk); #1;
    wb_burst(32'h1010, 1'b0, 2'b00, 4, 0);
    vectors++; if (nacks != 4 || ncyc != 5) begin miscompares++; $display("FAIL lin_rd_acks: got %0d in %0d cycles want 4 in 5", nacks, ncyc); end
    for (int i = 0; i < 4; i++) begin
      vectors++; if (bdat[i] !== 32'(i + 1)) begin miscompares++; $display("FAIL lin_rd_beat%0d: got %h want %h", i, bdat[i], i + 1); end
    end
    wb_burst(32'h1010, 1'b0, 2'b00, 8, 0);
    vectors++; if (nacks != 8) begin miscompares++; $display("FAIL lin_rd8_acks: got %0d want 8", nacks); end
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (bdat[i] !== ref_mem[widx(32'h1010) + i]) begin
        miscompares++; $display("FAIL lin_rd8_beat%0d: got %h want %h", i, bdat[i], ref_mem[widx(32'h1010) + i]);
      end
    end
  endtask

  task automatic test_burst_wrap();
    logic [31:0] exp_a [4];
    exp_a[0] = 32'h1018; exp_a[1] = 32'h101C; exp_a[2] = 32'h1010; exp_a[3] = 32'h1014;
    wb_burst(32'h1018, 1'b0, 2'b01, 4, 0);
    vectors++; if (nacks != 4) begin miscompares++; $display("FAIL wrap4_acks: got %0d want 4", nacks); end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (bdat[i] !== ref_mem[widx(exp_a[i])]) begin
        miscompares++; $display("FAIL wrap4_beat%0d: got %h want %h", i, bdat[i], ref_mem[widx(exp_a[i])]);
      end
    end
  endtask

  task automatic test_random_bursts();
    logic [31:0] a;
    logic [1:0]  b;
    logic        w;
    int          n, k;
    for (int it = 0; it < 30; it++) begin
      b = 2'($urandom_range(0, 3)); w = 1'($urandom_range(0, 1)); n = $urandom_range(2, 16);
      a = BASE + 32'(4 * $urandom_range(0, 255));
      for (int i = 0; i < n; i++) begin wdat[i] = $urandom; wsel[i] = 4'($urandom_range(0, 15)); end
      k = 0;
      while (k < n && in_rng(beat_addr(a, b, k))) k++;
      wb_burst(a, w, b, n, 0);
      vectors++;
      if (nacks != k || ge !== (k < n)) begin
        miscompares++; $display("FAIL rand_burst%0d acks: got %0d err=%b want %0d err=%b (a=%h bte=%0d n=%0d)", it, nacks, ge, k, k < n, a, b, n);
      end
      for (int i = 0; i < nacks && i < k; i++) begin
        if (w) ref_write(beat_addr(a, b, i), wdat[i], wsel[i]);
        else begin
          vectors++;
          if (bdat[i] !== ref_mem[widx(beat_addr(a, b, i))]) begin
            miscompares++; $display("FAIL rand_burst%0d beat%0d: got %h want %h", it, i, bdat[i], ref_mem[widx(beat_addr(a, b, i))]);
          end
        end
      end
    end
  endtask

  task automatic test_range();
    wb_classic(32'h0FFC, 1'b0, 32'h0, 4'hF);
    vectors++; if ({ga, ge} !== 2'b01 || ncyc != 2) begin miscompares++; $display("FAIL range_low: ack=%b err=%b cycles=%0d want 0/1/2", ga, ge, ncyc); end
    vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL range_low_dat: got %h want 0", rd); end
    @(negedge clk);
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL range_err_one_cycle: got %b want 0", err); end
    @(posedge clk); #1;
    wb_classic(32'h1400, 1'b1, 32'h55AA55AA, 4'hF);
    vectors++; if ({ga, ge} !== 2'b01) begin miscompares++; $display("FAIL range_high: ack=%b err=%b want 0/1", ga, ge); end
    wb_burst(32'h13FC, 1'b0, 2'b00, 4, 0);
    vectors++; if (nacks != 1 || ge !== 1'b1) begin miscompares++; $display("FAIL range_burst_end: acks=%0d err=%b want 1/1", nacks, ge); end
    vectors++; if (bdat[0] !== ref_mem[255]) begin miscompares++; $display("FAIL range_burst_beat0: got %h want %h", bdat[0], ref_mem[255]); end
    wb_classic(32'h1000, 1'b0, 32'h0, 4'hF);
    vectors++; if (ga !== 1'b1 || rd !== ref_mem[0]) begin miscompares++; $display("FAIL range_recover: ack=%b data=%h want %h", ga, rd, ref_mem[0]); end
  endtask

  task automatic test_stb_drop();
    for (int i = 0; i < 4; i++) begin wdat[i] = $urandom; wsel[i] = 4'hF; end
    wb_burst(32'h1020, 1'b1, 2'b00, 4, 2);
    for (int i = 0; i < nacks && i < 2; i++) ref_write(beat_addr(32'h1020, 2'b00, i), wdat[i], wsel[i]);
    vectors++; if (nacks != 2) begin miscompares++; $display("FAIL stbdrop_acks: got %0d want 2", nacks); end
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    vectors++; if (ack !== 1'b0) begin miscompares++; $display("FAIL stbdrop_ack_low: got %b want 0", ack); end
    @(posedge clk); #1;
    wb_classic(32'h1010, 1'b0, 32'h0, 4'hF);
    vectors++; if (rd !== ref_mem[widx(32'h1010)]) begin miscompares++; $display("FAIL stbdrop_new_read: got %h want %h", rd, ref_mem[widx(32'h1010)]); end
    wb_classic(32'h1028, 1'b0, 32'h0, 4'hF);
    vectors++; if (rd !== ref_mem[widx(32'h1028)]) begin miscompares++; $display("FAIL stbdrop_no_write: got %h want %h", rd, ref_mem[widx(32'h1028)]); end
  endtask

  task automatic test_reset_mid_burst();
    logic        seen;
    logic [31:0] a;
    seen = 0;
    cyc = 1; stb = 1; we = 0; addr = 32'h1040; cti = 3'b010; bte = 2'b00; sel = 4'hF;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack) begin seen = 1; break; end
    end
    vectors++; if (seen !== 1'b1) begin miscompares++; $display("FAIL rstmid_burst_start: ack seen=%b want 1", seen); end
    #1 rst_n = 0;
    #1;
    vectors++; if (ack !== 1'b0) begin miscompares++; $display("FAIL rstmid_async_ack: got %b want 0", ack); end
    vectors++; if (dat_r !== 32'h0) begin miscompares++; $display("FAIL rstmid_dat: got %h want 0", dat_r); end
    idle_bus();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      a = BASE + 32'(4 * $urandom_range(0, 255));
      wb_classic(a, 1'b0, 32'h0, 4'hF);
      vectors++;
      if (ga !== 1'b1 || rd !== ref_mem[widx(a)]) begin
        miscompares++; $display("FAIL rstmid_retained @%h: ack=%b got %h want %h", a, ga, rd, ref_mem[widx(a)]);
      end
    end
  endtask

  initial begin
    clk = 0; rst_n = 0; addr = '0; dat_w = '0;
    vectors = 0; miscompares = 0;
    idle_bus();
    test_reset();
    test_fill();
    test_classic();
    test_byte_enables();
    test_random_classic();
    test_burst_linear();
    test_burst_wrap();
    test_random_bursts();
    test_range();
    test_stb_drop();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
